// File: rtl/opc7_uart_tx.sv
// OPC7 I/O-bus UART transmitter: FIFO-buffered 8N1 serialiser with DATA/STATUS/CTRL registers.
// Define OPC7_UART_IRQ_EN to implement CTRL.ien and the active-low irq_b output.
module opc7_uart_tx #(
  parameter logic [15:0] BASE         = 16'hFE08,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [31:0] dout,
  output logic [31:0] din,
  input  logic        rnw,
  input  logic        vio,
  input  logic        clken,
  output logic        txd,
  output logic        irq_b
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [15:0] AddrStat = BASE + 16'd1;
  localparam logic [15:0] AddrCtrl = BASE + 16'd2;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic          txd_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [31:0]   din_q;
  logic          ien;

  logic sel, wr_data, rd_stat, full, empty, busy, baud_last, push, pop;
  logic [31:0] status, rd_data;
  logic unused_dout;

  assign unused_dout = ^dout[31:8];

  assign sel = vio & clken &
               ((address == BASE) | (address == AddrStat) | (address == AddrCtrl));
  assign wr_data   = sel & ~rnw & (address == BASE);
  assign rd_stat   = sel & rnw & (address == AddrStat);
  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != StIdle);
  assign baud_last = (baud_q == BaudLast);
  // Fullness is judged before any same-cycle pop, so a write while full is always dropped.
  assign push = wr_data & ~full;
  assign pop  = ~empty & ((state_q == StIdle) | ((state_q == StStop) & baud_last));

  always_comb begin
    status       = '0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = busy;
    status[3]    = ovf_q;
    status[11:8] = 4'(count_q);
    rd_data      = '0;
    if (address == AddrStat) begin
      rd_data = status;
    end else if (address == AddrCtrl) begin
      rd_data[0] = ien;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= dout[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (sel & rnw) din_q <= rd_data;
      if (wr_data & full) begin
        ovf_q <= 1'b1;
      end else if (rd_stat) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shreg_q <= mem_q[rptr_q];
            txd_q   <= 1'b0;
            baud_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q   <= '0;
            bitcnt_q <= '0;
            txd_q    <= shreg_q[0];
            shreg_q  <= {1'b0, shreg_q[7:1]};
            state_q  <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bitcnt_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= StStop;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
              txd_q    <= shreg_q[0];
              shreg_q  <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shreg_q <= mem_q[rptr_q];
              txd_q   <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef OPC7_UART_IRQ_EN
  logic ien_q, irq_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q   <= 1'b0;
      irq_b_q <= 1'b1;
    end else begin
      if (sel & ~rnw & (address == AddrCtrl)) ien_q <= dout[0];
      irq_b_q <= ~(ien_q & empty & ~busy);
    end
  end

  assign ien   = ien_q;
  assign irq_b = irq_b_q;
`else
  assign ien   = 1'b0;
  assign irq_b = 1'b1;
`endif

  assign din = din_q;
  assign txd = txd_q;

endmodule

// File: tb/tb_opc7_uart_tx.sv
// Randomised bench for opc7_uart_tx: bus tasks, a serial-line decoder and an expected-byte queue.
module tb_opc7_uart_tx;

  localparam logic [15:0] BASE = 16'hFE08;
  localparam logic [15:0] STAT = BASE + 16'd1;
  localparam logic [15:0] CTRL = BASE + 16'd2;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic [31:0] dout = '0;
  logic [31:0] din;
  logic        rnw = 1'b1;
  logic        vio = 1'b0;
  logic        clken = 1'b1;
  logic        txd;
  logic        irq_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rx_en    = 1'b1;
  logic [7:0] exp_q[$];
  int rx_starts[$];

  opc7_uart_tx #(.BASE(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .address(address), .dout(dout), .din(din), .rnw(rnw),
    .vio(vio), .clken(clken), .txd(txd), .irq_b(irq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // STATUS value built from the register layout: full, empty, busy, ovf, count.
  function automatic logic [31:0] spec_status(input int cnt, input bit bsy, input bit ovf);
    return (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(bsy) << 2) |
           (32'(cnt == 0) << 1) | 32'(cnt == DEPTH);
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic ce);
    vio = 1'b1; clken = ce; rnw = 1'b0; address = a; dout = d;
    @(negedge clk);
    vio = 1'b0; clken = 1'b1; rnw = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    vio = 1'b1; rnw = 1'b1; address = a;
    @(negedge clk);
    vio = 1'b0;
    d = din;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    s = '1;
    for (int i = 0; i < 600; i++) begin
      bus_read(STAT, s);
      if (s == 32'h2) break;
    end
    check(tag, s, 32'h2);
  endtask

  // Serial decoder: samples mid-bit and compares each frame with the expected queue.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (rx_en && txd === 1'b0) begin
        rx_starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        check("rx_start_bit", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        check("rx_stop_bit", txd, 1'b1);
        if (exp_q.size() == 0) check("rx_unexpected_frame", {56'd0, rx}, 64'hdead);
        else check("rx_byte", rx, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  v;
    logic [39:0] obs, expv;
    int base, lows, waited;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_txd", txd, 1'b1);
    check("reset_irq_b", irq_b, 1'b1);
    check("reset_din", din, 32'h0);
    bus_read(STAT, d);
    check("reset_status", d, spec_status(0, 0, 0));
    bus_read(BASE, d);
    check("data_reads_zero", d, 32'h0);
    bus_read(STAT, d);
    bus_read(BASE + 16'd3, d);
    check("unselected_read_holds", d, 32'h2);

    // Exact waveform of 0x41; upper data bits must be ignored.
    exp_q.push_back(8'h41);
    bus_write(BASE, 32'hFFFF_FF41, 1'b1);
    check("start_not_before_e1", txd, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      obs[i] = txd;
    end
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        v = 8'h41;
        expv[k*CPB + j] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : v[k-1];
      end
    end
    check("frame_0x41_waveform", obs, expv);
    wait_idle("idle_after_0x41");

    // Random bursts with random gaps; clken=0 writes must never reach the line.
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        v = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          bus_write(BASE, {24'($urandom), v}, 1'b0);
        end else begin
          exp_q.push_back(v);
          bus_write(BASE, {24'($urandom), v}, 1'b1);
        end
        repeat ($urandom_range(0, 15)) @(negedge clk);
      end
      wait_idle("idle_after_burst");
      check("burst_drained", exp_q.size(), 0);
    end

    bus_write(BASE, 32'h55, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(STAT, d);
    check("clken_low_write_ignored", d, spec_status(0, 0, 0));

`ifdef OPC7_UART_IRQ_EN
    bus_write(CTRL, 32'h1, 1'b1);
    check("irq_lags_ctrl", irq_b, 1'b1);
    @(negedge clk);
    check("irq_asserts", irq_b, 1'b0);
    bus_read(CTRL, d);
    check("ctrl_readback", d, 32'h1);
    v = 8'($urandom);
    exp_q.push_back(v);
    bus_write(BASE, {24'd0, v}, 1'b1);
    check("irq_low_at_push", irq_b, 1'b0);
    @(negedge clk);
    check("irq_deasserts", irq_b, 1'b1);
    waited = 0;
    while (irq_b !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("irq_reassert_delay", waited, 10 * CPB + 1);
    bus_write(CTRL, 32'h0, 1'b1);
    @(negedge clk);
    check("irq_off", irq_b, 1'b1);
`else
    bus_write(CTRL, 32'h1, 1'b1);
    bus_read(CTRL, d);
    check("ctrl_reads_zero", d, 32'h0);
    repeat (3) @(negedge clk);
    check("irq_tied_high", irq_b, 1'b1);
`endif

    // Ten back-to-back writes: nine fit, the tenth overflows.
    base = rx_starts.size();
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom);
      if (i < 9) exp_q.push_back(v);
      bus_write(BASE, {24'd0, v}, 1'b1);
    end
    bus_read(STAT, d);
    check("status_overflow", d, spec_status(DEPTH, 1, 1));
    bus_read(STAT, d);
    check("status_ovf_cleared", d, spec_status(DEPTH, 1, 0));
    wait_idle("idle_after_overflow");
    check("overflow_drained", exp_q.size(), 0);
    check("overflow_frame_count", rx_starts.size() - base, 9);
    for (int i = 1; i < 9 && base + i < rx_starts.size(); i++) begin
      check("back_to_back_spacing", rx_starts[base+i] - rx_starts[base+i-1], 10 * CPB);
    end

    // Reset in the middle of a frame with three bytes queued.
    rx_en = 1'b0;
    bus_write(BASE, 32'h00, 1'b1);
    for (int i = 0; i < 3; i++) bus_write(BASE, 32'($urandom_range(0, 255)), 1'b1);
    repeat (14) @(negedge clk);
    bus_read(STAT, d);
    check("status_three_queued", d, spec_status(3, 1, 0));
    check("mid_frame_low", txd, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_txd", txd, 1'b1);
    reset = 1'b0;
    bus_read(STAT, d);
    check("status_after_abort", d, spec_status(0, 0, 0));
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("no_frames_after_reset", lows, 0);
    rx_en = 1'b1;

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opc7_uart_tx.md
# opc7_uart_tx

Memory-mapped UART transmitter on the OPC7 I/O bus (`vio` space). It sits directly downstream of `opc7cpu` and consumes the CPU's OUT writes. Bytes are queued in a small FIFO and serialised 8N1 on `txd`. An optional active-low interrupt feeds the CPU's `int_b[1]` input.

## Interface
Parameters:
- `BASE`, 16'hFE08, I/O address of the DATA register; STATUS is at `BASE+1`, CTRL is at `BASE+2`.
- `DEPTH`, 8, FIFO entries; must be a power of 2, at least 2.
- `CLKS_PER_BIT`, 16, `clk` cycles per serial bit; must be at least 2.

Ports:
- `clk`  in  1  system clock, shared with `opc7cpu`.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  16  I/O address, taken from the CPU `address[15:0]`.
- `dout`  in  32  CPU write data; only bits [7:0] are used.
- `din`  out  32  read data to the CPU, registered.
- `rnw`  in  1  1 = read, 0 = write.
- `vio`  in  1  I/O cycle valid.
- `clken`  in  1  CPU clock enable; qualifies bus accesses only.
- `txd`  out  1  serial output, idles high.
- `irq_b`  out  1  active-low interrupt to `int_b[1]`.

## Operation
- Access select: `sel = vio & clken & (address` in `BASE..BASE+2)`.
- `clken` does not gate the transmit engine.
- Write DATA (`sel & !rnw & address==BASE`):
  - if the FIFO is not full, push `dout[7:0]`;
  - otherwise drop the byte and set the sticky `ovf` flag.
- Fullness is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs in that cycle.
- STATUS read layout:
  - [0] full
  - [1] empty
  - [2] busy (FSM not IDLE)
  - [3] `ovf`
  - [11:8] FIFO count, 0..DEPTH
  - all other bits 0
- A STATUS read clears `ovf` on the same edge. If an overflow happens on that same edge, `ovf` stays set.
- CTRL (R/W): bit [0] is `ien`. All other bits read 0.
- DATA reads as 0.
- Reads of unselected addresses leave `din` unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE -> START when the FIFO is non-empty. On that edge, pop the head into `shreg` and drive `txd` to 0.
  - START holds for `CLKS_PER_BIT` cycles, then -> DATA.
  - DATA sends `shreg` LSB first, each bit for `CLKS_PER_BIT` cycles. An `bitcnt` counter runs 0..7; after bit 7 -> STOP.
  - STOP drives `txd`=1 for `CLKS_PER_BIT` cycles. On its last cycle:
    - if the FIFO is non-empty, pop and -> START, with no idle gap;
    - otherwise -> IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, is reset on each state entry, and wraps without drift.
- FIFO: circular buffer with read and write pointers of `log2(DEPTH)` bits, wrapping modulo DEPTH. `count` is `log2(DEPTH)+1` bits wide. A push and a pop in the same cycle leave `count` unchanged.
- Interrupt: `irq_b = !(ien & empty & !busy)`, registered.

## Timing
- Reset values:
  - `txd`=1, `irq_b`=1, `din`=0;
  - FIFO empty, pointers 0, `ovf`=0, `ien`=0;
  - FSM IDLE, counters 0.
- A reset mid-frame aborts the frame. `txd`=1 on the next edge and queued bytes are discarded.
- Read latency: `din` is valid after the edge that samples the access, i.e. on the next CPU posedge, matching the memory model.
- Write takes effect on the sampling edge.
- Write to idle UART: push on edge E0. Pop and `txd` falls on E1. The frame occupies exactly 10×`CLKS_PER_BIT` cycles from E1.
- Back-to-back bytes: the next start bit begins exactly 10×`CLKS_PER_BIT` cycles after the previous one.
- `irq_b` lags its conditions by one cycle.
  - It deasserts one cycle after a DATA push, since `empty` falls at E0.
  - It reasserts one cycle after returning to IDLE with the FIFO empty.

## Configuration
- `OPC7_UART_IRQ_EN` defined: CTRL register is implemented and `irq_b` behaves as specified.
- `OPC7_UART_IRQ_EN` undefined:
  - `irq_b` is tied to 1;
  - CTRL reads 0 and writes to it are ignored;
  - all other behaviour is identical.

## Test plan
- Reset, then read STATUS -> `din`=32'h0000_0002 (empty only); `txd`=1, `irq_b`=1.
- With `CLKS_PER_BIT`=4, write 0x41 to `BASE` -> `txd` pattern 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles; start bit begins 1 cycle after the write.
- Write 9 bytes back-to-back with `DEPTH`=8 while the first frame is in flight:
  - all 9 bytes are accepted, because one is popped after the first write;
  - a 10th write sets STATUS[3]=1;
  - the next STATUS read returns `ovf`=1, and a read after that returns 0.
- Write CTRL=1 with the UART idle -> `irq_b`=0 one cycle later. Write DATA -> `irq_b`=1 one cycle after that. After the frame completes, `irq_b`=0.
- Assert `reset` mid-DATA with 3 bytes queued -> `txd`=1 on the next edge, STATUS=0x2, no further frames.
- Hold `clken`=0 during a DATA write -> the byte is ignored and the FIFO stays empty; a frame already in progress continues unaffected.
